// File: rtl/fp_square_if.sv
// go/done handshake bundle for the sequential fixed-point squarer.
// The squarer takes the slave side; the invoking controller takes the master side.
interface fp_square_if #(
    parameter int WIDTH = 32
) ();
    logic             go;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             done;
    logic             overflow;

    modport master (
        output go,
        output in,
        input  out,
        input  done,
        input  overflow
    );

    modport slave (
        input  go,
        input  in,
        output out,
        output done,
        output overflow
    );
endinterface

// File: rtl/fp_square.sv
// Sequential unsigned fixed-point squarer, one shift-add step per cycle, go/done handshake.
// Define FP_SQUARE_SAT_EN to saturate out to all ones whenever overflow is flagged.
module fp_square #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16
) (
    input logic        clk,
    input logic        reset_n,
    fp_square_if.slave bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_format_check
        $error("fp_square: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
    logic [PW-1:0]    p;
    logic [IDX_W-1:0] idx;
    logic [PW-1:0]    addend;

    // Anything above the top of the output window cannot be represented.
    function automatic logic range_overflow(input logic [PW-1:0] prod);
        return |(prod >> (WIDTH + FRAC_WIDTH));
    endfunction

    // Drop the low FRAC_WIDTH product bits: truncation toward zero.
    function automatic logic [WIDTH-1:0] extract(input logic [PW-1:0] prod);
        return prod[FRAC_WIDTH +: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] value,
                                                  input logic             ovf);
`ifdef FP_SQUARE_SAT_EN
        return ovf ? {WIDTH{1'b1}} : value;
`else
        return ovf ? value : value;
`endif
    endfunction

    always_comb begin
        addend = '0;
        if (q[0]) begin
            addend = {{WIDTH{1'b0}}, m} << idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            m            <= '0;
            q            <= '0;
            p            <= '0;
            idx          <= '0;
            bus.out      <= '0;
            bus.overflow <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        m     <= bus.in;
                        q     <= bus.in;
                        p     <= '0;
                        idx   <= '0;
                        state <= BUSY;
                    end
                end
                // One multiplier bit per cycle, LSB first.
                BUSY: begin
                    p   <= p + addend;
                    q   <= q >> 1;
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                // p now holds the exact product; window it into the output format.
                DONE: begin
                    bus.out      <= saturate(extract(p), range_overflow(p));
                    bus.overflow <= range_overflow(p);
                    bus.done     <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_square.sv
// Scoreboard bench for fp_square: a 32-bit Q16.16 instance and an 8-bit integer instance.
// Drivers push expected results on acceptance; one monitor pops and compares on done.
module tb_fp_square;
    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_square_if #(.WIDTH(32)) bus32 ();
    fp_square_if #(.WIDTH(8))  bus8 ();

    fp_square #(.WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16)) dut32 (
        .clk(clk), .reset_n(reset_n), .bus(bus32.slave)
    );
    fp_square #(.WIDTH(8), .INT_WIDTH(8), .FRAC_WIDTH(0)) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8.slave)
    );

    typedef struct {
        logic [31:0] operand;
        logic [31:0] out;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        q32[$];
    exp_t        q8[$];
    logic [31:0] last32;
    logic [31:0] last8;

    // Reference: exact square, keep the window above the fraction bits.
    function automatic logic [32:0] ref32(input logic [31:0] x);
        logic [63:0] prod;
        logic [31:0] o;
        logic        ovf;
        prod = {32'b0, x} * {32'b0, x};
        ovf  = (prod >> 48) != 0;
        o    = 32'(prod >> 16);
`ifdef FP_SQUARE_SAT_EN
        if (ovf) o = 32'hFFFF_FFFF;
`endif
        return {ovf, o};
    endfunction

    function automatic logic [8:0] ref8(input logic [7:0] x);
        logic [15:0] prod;
        logic [7:0]  o;
        logic        ovf;
        prod = {8'b0, x} * {8'b0, x};
        ovf  = (prod >> 8) != 0;
        o    = 8'(prod);
`ifdef FP_SQUARE_SAT_EN
        if (ovf) o = 8'hFF;
`endif
        return {ovf, o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Monitor: reset-state checks while reset is low, scoreboard compare on done, hold otherwise.
    initial begin
        exp_t e;
        last32 = '0;
        last8  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                q32.delete();
                q8.delete();
                last32 = '0;
                last8  = '0;
                check("reset_done32", 32'(bus32.done), 32'd0);
                check("reset_out32", bus32.out, 32'd0);
                check("reset_ovf32", 32'(bus32.overflow), 32'd0);
                check("reset_done8", 32'(bus8.done), 32'd0);
                check("reset_out8", 32'(bus8.out), 32'd0);
                check("reset_ovf8", 32'(bus8.overflow), 32'd0);
            end else begin
                if (bus32.done) begin
                    if (q32.size() == 0) begin
                        check("unexpected_done32", 32'(bus32.done), 32'd0);
                    end else begin
                        e = q32.pop_front();
                        check($sformatf("out32 in=%h", e.operand), bus32.out, e.out);
                        check($sformatf("ovf32 in=%h", e.operand), 32'(bus32.overflow), 32'(e.ovf));
                        check($sformatf("latency32 in=%h", e.operand), 32'(cyc), 32'(e.cyc));
                        last32 = e.out;
                    end
                end else begin
                    check("hold32", bus32.out, last32);
                end
                if (bus8.done) begin
                    if (q8.size() == 0) begin
                        check("unexpected_done8", 32'(bus8.done), 32'd0);
                    end else begin
                        e = q8.pop_front();
                        check($sformatf("out8 in=%h", e.operand), 32'(bus8.out), e.out);
                        check($sformatf("ovf8 in=%h", e.operand), 32'(bus8.overflow), 32'(e.ovf));
                        check($sformatf("latency8 in=%h", e.operand), 32'(cyc), 32'(e.cyc));
                        last8 = e.out;
                    end
                end else begin
                    check("hold8", 32'(bus8.out), last8);
                end
            end
        end
    end

    // Called at a negedge with the DUT idle; returns just after the accepting edge.
    task automatic issue32(input logic [31:0] x, input bit hold);
        logic [32:0] r;
        r         = ref32(x);
        bus32.in  = x;
        bus32.go  = 1'b1;
        @(posedge clk);
        #1;
        q32.push_back('{operand: x, out: r[31:0], ovf: r[32], cyc: cyc + 33});
        bus32.in = $urandom;
        if (!hold) bus32.go = 1'b0;
    endtask

    task automatic wait32(input bit keep_go);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (bus32.done) seen = 1'b1;
            else bus32.in = $urandom;
        end
        if (!seen) begin
            $display("FAIL done_timeout32: no done within 80 cycles, expected one");
            $fatal(1, "32-bit squarer stalled");
        end
        if (!keep_go) bus32.go = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] x, input bit hold);
        logic [8:0] r;
        r        = ref8(x);
        bus8.in  = x;
        bus8.go  = 1'b1;
        @(posedge clk);
        #1;
        q8.push_back('{operand: 32'(x), out: 32'(r[7:0]), ovf: r[8], cyc: cyc + 9});
        bus8.in = 8'($urandom);
        if (!hold) bus8.go = 1'b0;
    endtask

    task automatic wait8(input bit keep_go);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus8.done) seen = 1'b1;
            else bus8.in = 8'($urandom);
        end
        if (!seen) begin
            $display("FAIL done_timeout8: no done within 30 cycles, expected one");
            $fatal(1, "8-bit squarer stalled");
        end
        if (!keep_go) bus8.go = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        reset_n  = 1'b1;
        bus32.go = 1'b0;
        bus32.in = '0;
        bus8.go  = 1'b0;
        bus8.in  = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // Q16.16 directed points and range boundaries
        issue32(32'h0003_0000, 1'b0); wait32(1'b0);
        issue32(32'h0000_8000, 1'b0); wait32(1'b0);
        issue32(32'h0000_0001, 1'b0); wait32(1'b0);
        issue32(32'h0100_0000, 1'b0); wait32(1'b0);
        issue32(32'h00FF_FFFF, 1'b0); wait32(1'b0);
        issue32(32'hFFFF_FFFF, 1'b0); wait32(1'b0);
        issue32(32'h0000_0000, 1'b0); wait32(1'b0);

        // go held through BUSY with in toggling, then held past done for a back-to-back run
        issue32(32'h0001_8000, 1'b1); wait32(1'b1);
        issue32(32'h0007_4000, 1'b1); wait32(1'b0);

        for (int i = 0; i < 16; i++) begin
            r = $urandom >> $urandom_range(0, 31);
            issue32(r, 1'($urandom_range(0, 1)));
            wait32(1'($urandom_range(0, 1)) && i != 15);
        end
        bus32.go = 1'b0;

        // Integer mode
        issue8(8'd15, 1'b0);  wait8(1'b0);
        issue8(8'd16, 1'b0);  wait8(1'b0);
        issue8(8'd255, 1'b0); wait8(1'b0);
        issue8(8'd0, 1'b1);   wait8(1'b1);
        issue8(8'd11, 1'b0);  wait8(1'b0);
        for (int i = 0; i < 20; i++) begin
            issue8(8'($urandom), 1'($urandom_range(0, 1)));
            wait8(1'b0);
        end

        // Reset in the middle of a computation: nothing may complete for it
        issue32(32'h0003_0000, 1'b0); wait32(1'b0);
        issue32(32'h0005_0000, 1'b0);
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (60) @(negedge clk);
        issue32(32'h0002_0000, 1'b0); wait32(1'b0);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1000000, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
